// File: rtl/tc_spi_responder.sv
// tc_spi_responder: read-only SPI slave serving 32-bit thermocouple frames, snapshotted every CONV_CYCLES.
// Define TC_RESP_FAULT_LATCH_EN for sticky fault bits that clear on frame_done.
module tc_spi_responder #(
    parameter int CONV_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] tc_temp_in,
    input  logic [11:0] junction_temp_in,
    input  logic [2:0]  fault_in,
    input  logic        cs_n,
    input  logic        sclk,
    output logic        miso,
    output logic        miso_oe,
    output logic        frame_done
);
    localparam int FRAME_BITS = 32;
    localparam int CW = $clog2(CONV_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;

    state_t                state, state_d;
    logic                  cs_s1, cs_s2, cs_d, sk_s1, sk_s2, sk_d;
    logic                  cs_fall, cs_rise, sclk_fall, sclk_rise;
    logic [CW-1:0]         conv_cnt;
    logic                  wrap, pending, reload, done_evt;
    logic [2:0]            fault_now;
    logic [FRAME_BITS-1:0] result, shift;
    logic [5:0]            bit_cnt;

    // cs_n syncs reset high so a deselected bus never looks like a fall
    always_ff @(posedge clk) begin
        if (rst) begin
            {cs_s1, cs_s2, cs_d} <= 3'b111;
            {sk_s1, sk_s2, sk_d} <= 3'b000;
        end else begin
            {cs_s1, cs_s2, cs_d} <= {cs_n, cs_s1, cs_s2};
            {sk_s1, sk_s2, sk_d} <= {sclk, sk_s1, sk_s2};
        end
    end

    assign cs_fall   = cs_d & ~cs_s2;
    assign cs_rise   = ~cs_d & cs_s2;
    assign sclk_rise = ~sk_d & sk_s2;
    assign sclk_fall = sk_d & ~sk_s2;
    assign wrap      = conv_cnt == CW'(CONV_CYCLES - 1);
    assign reload    = (wrap & cs_s2) | (pending & cs_rise);
    assign done_evt  = (state == SHIFT) & cs_rise & (bit_cnt == 6'd32);

    always_ff @(posedge clk) begin
        if (rst) begin
            conv_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            conv_cnt <= wrap ? '0 : conv_cnt + 1'b1;
            pending  <= (wrap & ~cs_s2) ? 1'b1 : (cs_rise ? 1'b0 : pending);
        end
    end

`ifdef TC_RESP_FAULT_LATCH_EN
    logic [2:0] flt, flt_base;
    assign flt_base  = done_evt ? 3'b000 : flt;
    assign fault_now = flt_base | fault_in;
    always_ff @(posedge clk) begin
        if (rst) flt <= 3'b000;
        else     flt <= reload ? fault_now : flt_base;
    end
`else
    assign fault_now = fault_in;
`endif

    always_ff @(posedge clk) begin
        if (rst)         result <= '0;
        else if (reload) result <= {tc_temp_in, 1'b0, |fault_now, junction_temp_in, 1'b0, fault_now};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = IDLE;
        case (state)
            IDLE:    state_d = cs_fall ? SHIFT : IDLE;
            SHIFT:   state_d = cs_rise ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        miso_oe = state == SHIFT;
        miso    = miso_oe & shift[FRAME_BITS-1];
    end

    // cs_rise takes priority over any sclk edge in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            shift      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_evt;
            if (cs_fall && (state == IDLE || state == SHIFT)) begin
                shift   <= result;
                bit_cnt <= '0;
            end else if (state == SHIFT && !cs_rise) begin
                if (sclk_rise) bit_cnt <= bit_cnt + 6'(bit_cnt != 6'd32);
                if (sclk_fall) shift <= {shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_tc_spi_responder.sv
// tb_tc_spi_responder: table, random and corner-case frames against a frame-packing model (default build).
module tb_tc_spi_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] tc_temp_in;
    logic [11:0] junction_temp_in;
    logic [2:0]  fault_in;
    logic        cs_n, sclk;
    logic        miso, miso_oe, frame_done;
    int          checks = 0, failures = 0, done_total = 0;

    tc_spi_responder #(.CONV_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .tc_temp_in(tc_temp_in), .junction_temp_in(junction_temp_in),
        .fault_in(fault_in), .cs_n(cs_n), .sclk(sclk), .miso(miso), .miso_oe(miso_oe),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) done_total++;

    typedef struct {
        logic [13:0] tc;
        logic [11:0] jt;
        logic [2:0]  f;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] pack(input logic [13:0] tc, input logic [11:0] jt, input logic [2:0] f);
        return {tc, 1'b0, |f, jt, 1'b0, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [13:0] tc, input logic [11:0] jt, input logic [2:0] f);
        @(negedge clk);
        tc_temp_in = tc;
        junction_temp_in = jt;
        fault_in = f;
        repeat (12) @(negedge clk);
    endtask

    task automatic select();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic deselect();
        @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // mode-0 controller: sample on sclk rise, 4 clk per phase
    task automatic shift_bits(input int n, output logic [31:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = {d[30:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic read_frame(output logic [31:0] d);
        select();
        shift_bits(32, d);
        deselect();
    endtask

    vec_t        tbl[6];
    logic [31:0] d, ea, eb;
    logic [13:0] rtc;
    logic [11:0] rjt;
    logic [2:0]  rf;
    int          done0;

    initial begin
        tbl[0] = '{14'h0642, 12'h190, 3'b000, 32'h19081900};
        tbl[1] = '{14'h0000, 12'h000, 3'b001, 32'h00010001};
        tbl[2] = '{14'h0000, 12'h000, 3'b000, 32'h00000000};
        tbl[3] = '{14'h3FFC, 12'h000, 3'b000, 32'hFFF00000};
        tbl[4] = '{14'h1FFF, 12'hFFF, 3'b111, 32'h7FFDFFF7};
        tbl[5] = '{14'h2000, 12'h800, 3'b100, 32'h80018004};

        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0;
        tc_temp_in = '0; junction_temp_in = '0; fault_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_oe", 32'(miso_oe), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            set_in(tbl[i].tc, tbl[i].jt, tbl[i].f);
            done0 = done_total;
            read_frame(d);
            chk($sformatf("table%0d_frame", i), d, tbl[i].exp);
            chk($sformatf("table%0d_done", i), 32'(done_total - done0), 32'd1);
        end

        // select latency, then abort after 10 bits
        set_in(14'h2000, 12'h800, 3'b100);
        done0 = done_total;
        @(negedge clk); cs_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("oe_before_3cyc", 32'(miso_oe), 32'd0);
        @(negedge clk);
        chk("oe_at_3cyc", 32'(miso_oe), 32'd1);
        chk("bit31_at_3cyc", 32'(miso), 32'd1);
        repeat (2) @(negedge clk);
        shift_bits(10, d);
        chk("abort_partial", d, 32'h200);
        @(negedge clk); cs_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_oe_2cyc", 32'(miso_oe), 32'd1);
        @(negedge clk);
        chk("abort_oe_3cyc", 32'(miso_oe), 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", 32'(done_total - done0), 32'd0);
        read_frame(d);
        chk("after_abort_frame", d, 32'h80018004);
        chk("after_abort_done", 32'(done_total - done0), 32'd1);

        // cs held low across several conversions while inputs change
        rtc = 14'($urandom); rjt = 12'($urandom); rf = 3'($urandom);
        ea = pack(rtc, rjt, rf);
        set_in(rtc, rjt, rf);
        select();
        rtc = 14'($urandom); rjt = 12'($urandom); rf = 3'($urandom);
        eb = pack(rtc, rjt, rf);
        tc_temp_in = rtc; junction_temp_in = rjt; fault_in = rf;
        shift_bits(32, d);
        deselect();
        chk("hold_old_data", d, ea);
        read_frame(d);
        chk("hold_new_data", d, eb);

        // reset mid-frame, then a frame before the first conversion
        set_in(14'h0642, 12'h190, 3'b010);
        done0 = done_total;
        select();
        shift_bits(16, d);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_oe", 32'(miso_oe), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_oe", 32'(miso_oe), 32'd1);
        shift_bits(32, d);
        deselect();
        chk("post_rst_frame", d, 32'h00000000);
        chk("post_rst_done", 32'(done_total - done0), 32'd1);

        for (int i = 0; i < 20; i++) begin
            rtc = 14'($urandom); rjt = 12'($urandom); rf = 3'($urandom);
            set_in(rtc, rjt, rf);
            done0 = done_total;
            read_frame(d);
            chk($sformatf("rand%0d_frame", i), d, pack(rtc, rjt, rf));
            chk($sformatf("rand%0d_done", i), 32'(done_total - done0), 32'd1);
            d = '0;
            read_frame(d);
            chk($sformatf("rand%0d_reread", i), d, pack(rtc, rjt, rf));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tc_spi_responder.md
# tc_spi_responder

Thermocouple-to-digital SPI responder: the read-only serial slave that a thermocouple controller polls for 32-bit temperature frames. It periodically snapshots thermocouple temperature, cold-junction temperature and fault inputs into a result register. It serializes that register MSB-first on MISO when the controller asserts chip select. It serves as the sensor-side endpoint in the thermocouple subsystem and as the bench-side stimulus partner for the controller.

## Interface
- CONV_CYCLES, default 100: clk cycles per conversion period (result register update interval); legal range ≥ 2.
- FRAME_BITS, default 32: bits per frame; fixed at 32, not overridable.
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tc_temp_in  input  14  thermocouple temperature, two's complement, 0.25 °C/LSB.
- junction_temp_in  input  12  cold-junction temperature, two's complement, 0.0625 °C/LSB.
- fault_in  input  3  {short-to-VCC, short-to-GND, open-circuit}.
- cs_n  input  1  chip select from controller, active low, asynchronous to clk.
- sclk  input  1  serial clock from controller, idle low, asynchronous to clk.
- miso  output  1  serial data out.
- miso_oe  output  1  high while the frame is selected (tri-state enable).
- frame_done  output  1  one-cycle pulse when a complete 32-bit frame has been read.

## Operation
- Frame layout: [31:18] = tc temperature, [17] = 0, [16] = OR of the three fault bits, [15:4] = junction temperature, [3] = 0, [2:0] = fault bits.
- cs_n and sclk each pass through a 2-flop synchronizer. Edges are detected on the synced values: cs_fall, cs_rise, sclk_fall, sclk_rise.
- Conversion counter conv_cnt runs 0..CONV_CYCLES-1 and wraps. At wrap, the result register is reloaded from the inputs if synced cs_n is high. If synced cs_n is low, a pending flag is set instead, and the reload happens on the cycle cs_rise is detected.
- State machine:
  - IDLE: miso_oe = 0, miso = 0. On cs_fall, load the shift register from the result register, clear bit_cnt, and go to SHIFT.
  - SHIFT: miso_oe = 1, miso = shift[31]. On sclk_rise, bit_cnt increments and saturates at 32. On sclk_fall, shift left and fill with 0. On cs_rise, go to IDLE; pulse frame_done if bit_cnt == 32.
  - Any illegal encoding goes to IDLE.
- Reads are non-destructive: repeated frames without an intervening conversion return identical data.
- Frames aborted early (cs_rise with bit_cnt < 32) produce no frame_done and leave the result register unchanged.

## Timing
- Reset values: miso = 0, miso_oe = 0, frame_done = 0, result register = 0, pending = 0, conv_cnt = 0, state = IDLE.
- cs_n fall to valid miso bit 31: 3 clk cycles (2 synchronizer + 1 load).
- sclk fall to next miso bit: 3 clk cycles.
- Controller constraint: sclk high and low phases ≥ 4 clk cycles each; the block performs no overspeed detection.
- Simultaneous conversion wrap and cs_fall: the shift register loads the pre-update result value. The update is deferred via pending, because synced cs_n is already low.
- Simultaneous sclk edge and cs_rise: cs_rise wins, and the edge is ignored.
- cs_fall while in SHIFT cannot occur. If synchronizer glitching produces one, it reloads and restarts the frame.
- rst mid-frame: returns to IDLE with miso_oe = 0 on the next edge. The controller sees a floating or zero line.
- frame_done asserts on the same cycle state returns to IDLE.

## Configuration
- TC_RESP_FAULT_LATCH_EN defined: fault bits are sticky. Each conversion ORs fault_in into the latched fault bits. The latched faults clear only on a frame_done, and that frame reports the faults first.
- TC_RESP_FAULT_LATCH_EN undefined: fault bits are a live snapshot taken at each conversion. No sticky state is generated.

## Test plan
- CONV_CYCLES = 8; tc = 14'h0642, junction = 12'h190, fault = 0; wait 1 conversion, read 32 bits → 32'h19081900, frame_done single pulse.
- tc = 0, junction = 0, fault = 3'b001 → frame 32'h00010001. Without the macro, after clearing fault and 1 conversion → 32'h00000000. With TC_RESP_FAULT_LATCH_EN and fault = 3'b001 held for exactly one conversion, then cleared: 2 consecutive frames return 32'h00010001 then 32'h00000000.
- Hold cs_n low across 3 conversion wraps while inputs change → frame data equals the value present before cs_fall. After cs_rise, the next frame reflects the newest inputs.
- Abort after 10 bits → no frame_done, miso_oe drops 3 cycles after cs_n rise, and the next full frame is correct.
- Assert rst at bit 16 → miso_oe = 0 and miso = 0 next cycle, and the subsequent full frame reads 32'h00000000 before the first conversion.
- Negative tc = 14'h3FFC (−1 °C) → frame[31:18] = 14'h3FFC.
